// File: rtl/char_motion.sv
// Player-motion engine: tick-paced gravity, jump and walk resolution against a
// synchronous collision map, plus warp table and item/power-up status.
module char_motion #(
  parameter int COORD_W   = 10,
  parameter int ADDR_W    = 20,
  parameter int MAP_W     = 960,
  parameter int MAP_H     = 501,
  parameter int START_X   = 220,
  parameter int START_Y   = 360,
  parameter int TICK_DIV  = 100000,
  parameter int JUMP_LEN  = 64,
  parameter int NUM_WARP  = 4,
  parameter int WARP_SPAN = 24
) (
  input  logic                        sys_clk,
  input  logic                        RST_N,
  input  logic [3:0]                  mov,
  input  logic                        death_in,
  input  logic                        poison_mushroom_in,
  input  logic                        star_in,
  input  logic                        flying_mushroom_in,
  input  logic                        fire_flower_in,
  input  logic [NUM_WARP-1:0]         warp_en,
  input  logic [NUM_WARP*COORD_W-1:0] warp_src_x,
  input  logic [NUM_WARP*COORD_W-1:0] warp_src_y,
  input  logic [NUM_WARP*COORD_W-1:0] warp_dst_x,
  input  logic [NUM_WARP*COORD_W-1:0] warp_dst_y,
  input  logic                        blk_data,
  output logic [ADDR_W-1:0]           blk_addr,
  output logic [COORD_W-1:0]          char_X,
  output logic [COORD_W-1:0]          char_Y,
  output logic                        dead,
  output logic                        flying_mushroom,
  output logic                        fire_flower,
  output logic                        poison_mushroom,
  output logic [3:0]                  star_cnt,
  output logic                        warped,
  output logic                        busy
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int JCNT_W = $clog2(JUMP_LEN + 1);

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
  localparam logic [JCNT_W-1:0]  JUMP_LAST  = JCNT_W'(JUMP_LEN);
  localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(MAP_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(MAP_H - 1);
  localparam logic [COORD_W-1:0] X_START    = COORD_W'(START_X);
  localparam logic [COORD_W-1:0] Y_START    = COORD_W'(START_Y);
  localparam logic [COORD_W:0]   SPAN_EXT   = (COORD_W+1)'(WARP_SPAN);
  localparam logic [ADDR_W-1:0]  STRIDE     = ADDR_W'(MAP_W);

  typedef enum logic [2:0] {
    IDLE, WARP, H_ADDR, H_WAIT, H_EVAL, V_ADDR, V_WAIT, V_EVAL
  } seq_t;

  typedef enum logic [1:0] {GROUND, FALL, RISE} air_t;

  seq_t state, state_nx;
  air_t air;

  logic [TICK_W-1:0]  tick_cnt;
  logic               tick;
  logic [JCNT_W-1:0]  jcnt;
  logic [JCNT_W-1:0]  jcnt_inc;
  logic [COORD_W-1:0] cand_x;
  logic [COORD_W-1:0] cand_y;
  logic               v_skip;
  logic               go_left;
  logic               go_right;
  logic               warp_hit;
  logic [COORD_W-1:0] warp_x;
  logic [COORD_W-1:0] warp_y;
  logic [COORD_W-1:0] probe_x;
  logic [COORD_W-1:0] probe_y;
  logic [ADDR_W-1:0]  probe_addr;
  logic               respawn;

  logic [4:0] evt_in;
  logic [4:0] evt_prev;
  logic [4:0] evt_rise;
  logic       death_rise;
  logic       poison_rise;
  logic       star_rise;
  logic       fly_rise;
  logic       fire_rise;
  logic       unused_down;

  assign unused_down = mov[2];

  // Tick divider
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  // Item edge detection
  assign evt_in   = {death_in, poison_mushroom_in, star_in, flying_mushroom_in, fire_flower_in};
  assign evt_rise = evt_in & ~evt_prev;
  assign {death_rise, poison_rise, star_rise, fly_rise, fire_rise} = evt_rise;

  // Horizontal request, limits checked before any candidate is formed
  assign go_left  = mov[1] & ~mov[0] & (char_X != '0);
  assign go_right = mov[0] & ~mov[1] & (char_X != X_MAX);

  // Vertical candidate from the post-H position
  always_comb begin
    cand_y = char_Y + 1'b1;
    v_skip = (char_Y == Y_MAX);
    if (air == RISE) begin
      cand_y = char_Y - 1'b1;
      v_skip = (char_Y == '0);
    end
  end

  assign jcnt_inc = jcnt + 1'b1;

  // Lowest enabled matching entry wins; window compare is widened to avoid wrap
  always_comb begin
    warp_hit = 1'b0;
    warp_x   = '0;
    warp_y   = '0;
    for (int unsigned i = 0; i < NUM_WARP; i++) begin
      if (!warp_hit && warp_en[i]
          && (char_X == warp_src_x[i*COORD_W +: COORD_W])
          && (char_Y >= warp_src_y[i*COORD_W +: COORD_W])
          && ({1'b0, char_Y} < {1'b0, warp_src_y[i*COORD_W +: COORD_W]} + SPAN_EXT)) begin
        warp_hit = 1'b1;
        warp_x   = warp_dst_x[i*COORD_W +: COORD_W];
        warp_y   = warp_dst_y[i*COORD_W +: COORD_W];
      end
    end
  end

  always_comb begin
    probe_x = char_X;
    probe_y = cand_y;
    if (state == H_ADDR) begin
      probe_x = cand_x;
      probe_y = char_Y;
    end
  end

  assign probe_addr = ADDR_W'(probe_x) + ADDR_W'(probe_y) * STRIDE;

  // Sequence FSM
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (tick) state_nx = WARP;
      WARP: begin
        if (dead || warp_hit)        state_nx = IDLE;
        else if (go_left || go_right) state_nx = H_ADDR;
        else                          state_nx = V_ADDR;
      end
      H_ADDR: state_nx = H_WAIT;
      H_WAIT: state_nx = H_EVAL;
      H_EVAL: state_nx = V_ADDR;
      V_ADDR: state_nx = v_skip ? IDLE : V_WAIT;
      V_WAIT: state_nx = V_EVAL;
      V_EVAL: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign respawn = (state == WARP) && dead;

  // Position, air state and probe address
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      char_X   <= X_START;
      char_Y   <= Y_START;
      air      <= FALL;
      jcnt     <= '0;
      cand_x   <= '0;
      blk_addr <= '0;
      warped   <= 1'b0;
    end else begin
      warped <= 1'b0;
      case (state)
        WARP: begin
          if (dead) begin
            char_X <= X_START;
            char_Y <= Y_START;
            air    <= FALL;
          end else if (warp_hit) begin
            char_X <= warp_x;
            char_Y <= warp_y;
            air    <= FALL;
            warped <= 1'b1;
          end else begin
            cand_x <= go_left ? char_X - 1'b1 : char_X + 1'b1;
          end
        end
        H_ADDR: blk_addr <= probe_addr;
        H_EVAL: if (!blk_data) char_X <= cand_x;
        V_ADDR: begin
          if (v_skip) air <= (air == RISE) ? FALL : GROUND;
          else        blk_addr <= probe_addr;
        end
        V_EVAL: begin
          case (air)
            GROUND: begin
              if (!blk_data) air <= FALL;
              else if (mov[3]) begin
                air  <= RISE;
                jcnt <= '0;
              end
            end
            FALL: begin
              if (!blk_data) char_Y <= cand_y;
              else           air    <= GROUND;
            end
            RISE: begin
              if (blk_data) air <= FALL;
              else begin
                char_Y <= cand_y;
                jcnt   <= jcnt_inc;
                if (jcnt_inc == JUMP_LAST) air <= FALL;
              end
            end
            default: air <= FALL;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Status flags; item edges are applied after a same-cycle respawn clear
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      evt_prev        <= '0;
      dead            <= 1'b0;
      flying_mushroom <= 1'b0;
      fire_flower     <= 1'b0;
      poison_mushroom <= 1'b0;
      star_cnt        <= '0;
    end else begin
      evt_prev <= evt_in;
      if (respawn) begin
        dead            <= 1'b0;
        flying_mushroom <= 1'b0;
        fire_flower     <= 1'b0;
      end
      if (star_rise && star_cnt != 4'hF) star_cnt <= star_cnt + 1'b1;
      if (fly_rise) flying_mushroom <= 1'b1;
      if (poison_rise) begin
        poison_mushroom <= 1'b1;
        if (fire_flower) fire_flower <= 1'b0;
        else             dead        <= 1'b1;
      end
      if (fire_rise)  fire_flower <= 1'b1;
      if (death_rise) dead        <= 1'b1;
    end
  end

endmodule

// File: tb/tb_char_motion.sv
// Self-checking bench for char_motion: directed scenarios plus a randomized
// walk, compared against a per-tick behavioural model of the motion rules.
module tb_char_motion;

  localparam int CW       = 10;
  localparam int AW       = 20;
  localparam int MAP_W    = 960;
  localparam int MAP_H    = 501;
  localparam int SX       = 220;
  localparam int SY       = 360;
  localparam int TICK_DIV = 8;
  localparam int JLEN     = 4;
  localparam int NW       = 4;
  localparam int SPAN     = 24;

  localparam int A_GROUND = 0;
  localparam int A_FALL   = 1;
  localparam int A_RISE   = 2;

  localparam logic [4:0] I_DEATH = 5'b10000;
  localparam logic [4:0] I_POIS  = 5'b01000;
  localparam logic [4:0] I_STAR  = 5'b00100;
  localparam logic [4:0] I_FLY   = 5'b00010;
  localparam logic [4:0] I_FIRE  = 5'b00001;

  logic                 sys_clk = 1'b0;
  logic                 RST_N = 1'b0;
  logic [3:0]           mov = '0;
  logic                 death_in = 1'b0;
  logic                 poison_mushroom_in = 1'b0;
  logic                 star_in = 1'b0;
  logic                 flying_mushroom_in = 1'b0;
  logic                 fire_flower_in = 1'b0;
  logic [NW-1:0]        warp_en = '0;
  logic [NW*CW-1:0]     warp_src_x = '0;
  logic [NW*CW-1:0]     warp_src_y = '0;
  logic [NW*CW-1:0]     warp_dst_x = '0;
  logic [NW*CW-1:0]     warp_dst_y = '0;
  logic                 blk_data;
  logic [AW-1:0]        blk_addr;
  logic [CW-1:0]        char_X;
  logic [CW-1:0]        char_Y;
  logic                 dead;
  logic                 flying_mushroom;
  logic                 fire_flower;
  logic                 poison_mushroom;
  logic [3:0]           star_cnt;
  logic                 warped;
  logic                 busy;

  char_motion #(
    .COORD_W(CW), .ADDR_W(AW), .MAP_W(MAP_W), .MAP_H(MAP_H),
    .START_X(SX), .START_Y(SY), .TICK_DIV(TICK_DIV), .JUMP_LEN(JLEN),
    .NUM_WARP(NW), .WARP_SPAN(SPAN)
  ) dut (
    .sys_clk(sys_clk), .RST_N(RST_N), .mov(mov),
    .death_in(death_in), .poison_mushroom_in(poison_mushroom_in),
    .star_in(star_in), .flying_mushroom_in(flying_mushroom_in),
    .fire_flower_in(fire_flower_in),
    .warp_en(warp_en), .warp_src_x(warp_src_x), .warp_src_y(warp_src_y),
    .warp_dst_x(warp_dst_x), .warp_dst_y(warp_dst_y),
    .blk_data(blk_data), .blk_addr(blk_addr),
    .char_X(char_X), .char_Y(char_Y),
    .dead(dead), .flying_mushroom(flying_mushroom), .fire_flower(fire_flower),
    .poison_mushroom(poison_mushroom), .star_cnt(star_cnt),
    .warped(warped), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Collision map: optional full floor row, full wall column, ceiling segment
  int floor_y = -1;
  int wall_x  = -1;
  int ceil_y  = -1;
  int ceil_x0 = 0;
  int ceil_x1 = -1;

  function automatic bit solid(input int x, input int y);
    return (y == floor_y) || (x == wall_x) || (y == ceil_y && x >= ceil_x0 && x <= ceil_x1);
  endfunction

  always @(posedge sys_clk) blk_data <= solid(int'(blk_addr) % MAP_W, int'(blk_addr) / MAP_W);

  // Bench-side tick phase
  int tb_cnt;
  always @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) tb_cnt <= 0;
    else        tb_cnt <= (tb_cnt == TICK_DIV - 1) ? 0 : tb_cnt + 1;
  end

  int w_en[NW], w_sx[NW], w_sy[NW], w_dx[NW], w_dy[NW];

  task automatic set_warp(input int i, input int en, input int sx, input int sy,
                          input int dx, input int dy);
    w_en[i] = en; w_sx[i] = sx; w_sy[i] = sy; w_dx[i] = dx; w_dy[i] = dy;
    warp_en[i] = (en != 0);
    warp_src_x[i*CW +: CW] = CW'(sx);
    warp_src_y[i*CW +: CW] = CW'(sy);
    warp_dst_x[i*CW +: CW] = CW'(dx);
    warp_dst_y[i*CW +: CW] = CW'(dy);
  endtask

  // Reference model state
  int m_x, m_y, m_air, m_jc, m_star;
  bit m_dead, m_fly, m_fire, m_poison;
  bit m_warp, m_hreq, m_vprobe;
  int m_haddr, m_vaddr;

  int errors = 0;
  int checks = 0;
  int tick_no = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (tick %0d): observed=%0d expected=%0d", tag, tick_no, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = SX; m_y = SY; m_air = A_FALL; m_jc = 0; m_star = 0;
    m_dead = 0; m_fly = 0; m_fire = 0; m_poison = 0;
  endtask

  // One full tick of motion rules, using flags as they stood before the tick
  task automatic model_motion(input logic [3:0] mv);
    int nx, ny;
    m_warp = 0; m_hreq = 0; m_vprobe = 0;
    if (m_dead) begin
      m_x = SX; m_y = SY; m_air = A_FALL;
      m_dead = 0; m_fly = 0; m_fire = 0;
      return;
    end
    for (int i = 0; i < NW; i++) begin
      if (w_en[i] != 0 && m_x == w_sx[i] && m_y >= w_sy[i] && m_y < w_sy[i] + SPAN) begin
        m_x = w_dx[i]; m_y = w_dy[i]; m_air = A_FALL; m_warp = 1;
        return;
      end
    end
    nx = m_x;
    if (mv[1] && !mv[0] && m_x > 0) begin nx = m_x - 1; m_hreq = 1; end
    else if (mv[0] && !mv[1] && m_x < MAP_W - 1) begin nx = m_x + 1; m_hreq = 1; end
    if (m_hreq) begin
      m_haddr = nx + m_y * MAP_W;
      if (!solid(nx, m_y)) m_x = nx;
    end
    if (m_air == A_RISE) begin
      if (m_y == 0) m_air = A_FALL;
      else begin
        ny = m_y - 1; m_vprobe = 1; m_vaddr = m_x + ny * MAP_W;
        if (solid(m_x, ny)) m_air = A_FALL;
        else begin
          m_y = ny; m_jc++;
          if (m_jc == JLEN) m_air = A_FALL;
        end
      end
    end else begin
      if (m_y == MAP_H - 1) m_air = A_GROUND;
      else begin
        ny = m_y + 1; m_vprobe = 1; m_vaddr = m_x + ny * MAP_W;
        if (solid(m_x, ny)) begin
          if (m_air == A_FALL) m_air = A_GROUND;
          else if (mv[3]) begin m_air = A_RISE; m_jc = 0; end
        end else begin
          if (m_air == A_GROUND) m_air = A_FALL;
          else m_y = ny;
        end
      end
    end
  endtask

  task automatic model_items(input logic [4:0] it);
    if ((it & I_STAR) != 0 && m_star < 15) m_star++;
    if ((it & I_FLY) != 0) m_fly = 1;
    if ((it & I_POIS) != 0) begin
      m_poison = 1;
      if (m_fire) m_fire = 0;
      else m_dead = 1;
    end
    if ((it & I_FIRE) != 0) m_fire = 1;
    if ((it & I_DEATH) != 0) m_dead = 1;
  endtask

  task automatic check_state();
    check("char_X", char_X, m_x);
    check("char_Y", char_Y, m_y);
    check("dead", dead, m_dead);
    check("flying_mushroom", flying_mushroom, m_fly);
    check("fire_flower", fire_flower, m_fire);
    check("poison_mushroom", poison_mushroom, m_poison);
    check("star_cnt", star_cnt, m_star);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_X"}, char_X, SX);
    check({tag, "_Y"}, char_Y, SY);
    check({tag, "_addr"}, blk_addr, 0);
    check({tag, "_flags"}, {dead, flying_mushroom, fire_flower, poison_mushroom}, 0);
    check({tag, "_star"}, star_cnt, 0);
    check({tag, "_warped"}, warped, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge sys_clk);
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic wait_tick_phase();
    int guard = 0;
    while (tb_cnt != TICK_DIV - 1) begin
      @(negedge sys_clk);
      guard++;
      if (guard > 4 * TICK_DIV) begin
        errors++; checks++;
        $error("FAIL tick_sync: no tick within %0d cycles", guard);
        break;
      end
    end
  endtask

  // Drives one tick: mov held, item pulses at cycle 3, checks through cycle 8
  task automatic run_tick(input logic [3:0] mv, input logic [4:0] it);
    int wcnt = 0;
    mov = mv;
    wait_tick_phase();
    tick_no++;
    model_motion(mv);
    @(negedge sys_clk);
    check("busy_warp", busy, 1);
    wcnt += int'(warped);
    @(negedge sys_clk);
    check("warped", warped, m_warp);
    wcnt += int'(warped);
    @(negedge sys_clk);
    if (m_hreq) check("h_addr", blk_addr, m_haddr);
    {death_in, poison_mushroom_in, star_in, flying_mushroom_in, fire_flower_in} = it;
    wcnt += int'(warped);
    @(negedge sys_clk);
    {death_in, poison_mushroom_in, star_in, flying_mushroom_in, fire_flower_in} = '0;
    wcnt += int'(warped);
    @(negedge sys_clk);
    wcnt += int'(warped);
    @(negedge sys_clk);
    if (m_vprobe) check("v_addr", blk_addr, m_vaddr);
    wcnt += int'(warped);
    @(negedge sys_clk);
    wcnt += int'(warped);
    @(negedge sys_clk);
    wcnt += int'(warped);
    check("busy_idle", busy, 0);
    check("warped_cycles", wcnt, m_warp);
    model_items(it);
    check_state();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int jy[10] = '{359, 358, 357, 356, 357, 358, 359, 360, 360, 360};
    logic [3:0] rmv;
    logic [4:0] rit;
    int r;

    for (int i = 0; i < NW; i++) set_warp(i, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge sys_clk);
    check_reset_vals("reset");
    RST_N = 1'b1;

    // Free fall on an empty map down to the floor limit
    for (int t = 0; t < 145; t++) run_tick(4'b0000, '0);
    check("floor_limit_Y", char_Y, MAP_H - 1);

    // Walk right on a solid row, then blocked by a wall column
    floor_y = 361;
    do_reset();
    run_tick(4'b0001, '0);
    check("walk1_X", char_X, 221);
    run_tick(4'b0001, '0);
    check("walk2_X", char_X, 222);
    check("walk2_Y", char_Y, 360);
    wall_x = 223;
    run_tick(4'b0001, '0);
    run_tick(4'b0001, '0);
    check("wall_X", char_X, 222);

    // Jump of JUMP_LEN rising ticks and fall back to the ground
    run_tick(4'b1000, '0);
    check("jump_start_Y", char_Y, 360);
    for (int t = 0; t < 10; t++) begin
      run_tick(4'b0000, '0);
      check("jump_Y", char_Y, jy[t]);
    end

    // Warp chain: entry 1 then entry 0; then entry 0 disabled
    floor_y = -1; wall_x = -1;
    set_warp(0, 1, 372, 260, 100, 430);
    set_warp(1, 1, 220, 350, 372, 270);
    do_reset();
    run_tick(4'b0000, '0);
    check("warp1_X", char_X, 372);
    check("warp1_Y", char_Y, 270);
    run_tick(4'b0000, '0);
    check("warp0_X", char_X, 100);
    check("warp0_Y", char_Y, 430);
    set_warp(0, 0, 372, 260, 100, 430);
    do_reset();
    run_tick(4'b0000, '0);
    run_tick(4'b0000, '0);
    check("nowarp_X", char_X, 372);
    check("nowarp_Y", char_Y, 271);
    set_warp(1, 0, 220, 350, 372, 270);

    // Fire flower absorbs one poison, second poison kills, next tick respawns
    run_tick(4'b0000, I_FIRE | I_FLY);
    run_tick(4'b0000, I_POIS);
    check("poison1_fire", fire_flower, 0);
    check("poison1_dead", dead, 0);
    check("poison1_flag", poison_mushroom, 1);
    run_tick(4'b0000, I_POIS);
    check("poison2_dead", dead, 1);
    run_tick(4'b0000, '0);
    check("respawn_X", char_X, SX);
    check("respawn_Y", char_Y, SY);
    check("respawn_dead", dead, 0);
    check("respawn_fly", flying_mushroom, 0);

    // Star counter saturation
    for (int t = 0; t < 16; t++) run_tick(4'b0000, I_STAR);
    check("star_sat", star_cnt, 15);

    // Asynchronous reset in the middle of a walking sequence
    mov = 4'b0001;
    wait_tick_phase();
    repeat (5) @(negedge sys_clk);
    check("mid_busy", busy, 1);
    RST_N = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    repeat (2) @(negedge sys_clk);
    RST_N = 1'b1;
    model_reset();

    // Randomized walk between warps, under a partial ceiling, with items
    floor_y = 400; wall_x = -1;
    ceil_y = 396; ceil_x0 = 225; ceil_x1 = 232;
    set_warp(0, 1, 240, 380, 205, 390);
    set_warp(1, 1, 200, 376, 235, 340);
    set_warp(2, 1, 240, 380, 500, 100);
    do_reset();
    for (int t = 0; t < 200; t++) begin
      rmv = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 23);
      case (r)
        0: rit = I_DEATH;
        1: rit = I_POIS;
        2: rit = I_STAR;
        3: rit = I_FLY;
        4: rit = I_FIRE;
        5: rit = I_POIS | I_FIRE;
        default: rit = '0;
      endcase
      run_tick(rmv, rit);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
